// File: rtl/bfly_r2_stage0_if.sv
// Complex sample stream: valid/ready handshake, packed {re, im} data and frame-last marker.
// Combinational bundle only: no latency.
// Backpressure: a beat moves only when strm_vld && strm_rdy.
interface bfly_r2_stage0_if #(
    parameter int DW = 32
);
    logic          strm_vld;
    logic          strm_rdy;
    logic [DW-1:0] strm_dat;
    logic          strm_last;

    modport master (output strm_vld, output strm_dat, output strm_last, input  strm_rdy);
    modport slave  (input  strm_vld, input  strm_dat, input  strm_last, output strm_rdy);
endinterface

// File: rtl/bfly_r2_stage0.sv
// First radix-2 DIT butterfly (W0 = 1): pairs (A, B), emits (A+B)/2 then (A-B)/2; BFLY_ROUND_EN selects round-half-up.
// Latency: sum one cycle after B is accepted, diff one cycle after the sum is consumed.
// Backpressure: output register holds while !ready; input stalls only when the result cannot be placed.
module bfly_r2_stage0 #(
    parameter int K  = 10,
    parameter int DW = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    bfly_r2_stage0_if.slave        in_if,
    bfly_r2_stage0_if.master       out_if
);
    localparam int H = DW / 2;
`ifdef BFLY_ROUND_EN
    localparam logic signed [H:0] RND = (H+1)'(1);
`else
    localparam logic signed [H:0] RND = (H+1)'(0);
`endif

    typedef enum logic [1:0] {WAIT_A, WAIT_B, DIFF} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] diff_q, diff_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          vld_q, vld_d;
    logic [K-1:0]  cnt_q, cnt_d;
    logic          rdy;
    logic          in_fire;
    logic          out_fire;
    logic [DW-1:0] sum_w;
    logic [DW-1:0] dif_w;

    // Frame position is rebuilt from the output count, so the upstream marker is not needed.
    logic unused_in_last;
    assign unused_in_last = in_if.strm_last;

    // One extra bit of headroom keeps the pre-shift result exact.
    function automatic logic [H-1:0] half_op(input logic [H-1:0] a, input logic [H-1:0] b,
                                             input logic sub);
        logic signed [H:0] ax;
        logic signed [H:0] bx;
        logic signed [H:0] r;
        ax = $signed({a[H-1], a});
        bx = $signed({b[H-1], b});
        r  = sub ? (ax - bx) : (ax + bx);
        r  = r + RND;
        r  = r >>> 1;
        return r[H-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        diff_d  = diff_q;
        dat_d   = dat_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        rdy     = 1'b1;

        sum_w = {half_op(a_q[DW-1:H], in_if.strm_dat[DW-1:H], 1'b0),
                 half_op(a_q[H-1:0],  in_if.strm_dat[H-1:0],  1'b0)};
        dif_w = {half_op(a_q[DW-1:H], in_if.strm_dat[DW-1:H], 1'b1),
                 half_op(a_q[H-1:0],  in_if.strm_dat[H-1:0],  1'b1)};

        case (state_q)
            WAIT_A:  rdy = 1'b1;
            WAIT_B:  rdy = !vld_q || out_if.strm_rdy;
            DIFF:    rdy = out_if.strm_rdy;
            default: rdy = 1'b1;
        endcase

        in_fire  = in_if.strm_vld && rdy;
        out_fire = vld_q && out_if.strm_rdy;

        // A consumed beat empties the register unless a new result lands below.
        if (out_fire) begin
            cnt_d = cnt_q + 1'b1;
            vld_d = 1'b0;
        end

        case (state_q)
            WAIT_A: begin
                if (in_fire) begin
                    a_d     = in_if.strm_dat;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (in_fire) begin
                    dat_d   = sum_w;
                    diff_d  = dif_w;
                    vld_d   = 1'b1;
                    state_d = DIFF;
                end
            end
            DIFF: begin
                if (out_fire) begin
                    dat_d = diff_q;
                    vld_d = 1'b1;
                    if (in_fire) begin
                        a_d     = in_if.strm_dat;
                        state_d = WAIT_B;
                    end else begin
                        state_d = WAIT_A;
                    end
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            diff_q  <= '0;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            diff_q  <= diff_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_if.strm_rdy   = rdy;
    assign out_if.strm_vld  = vld_q;
    assign out_if.strm_dat  = dat_q;
    assign out_if.strm_last = vld_q && (cnt_q == {K{1'b1}});
endmodule

// File: tb/tb_bfly_r2_stage0.sv
// Bench for bfly_r2_stage0 (K=3, DW=32): directed steps with random data checked against a pair/queue model.
module tb_bfly_r2_stage0;
    localparam int K  = 3;
    localparam int N  = 1 << K;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bfly_r2_stage0_if #(.DW(DW)) in_if ();
    bfly_r2_stage0_if #(.DW(DW)) out_if ();

    bfly_r2_stage0 #(.K(K), .DW(DW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .in_if  (in_if),
        .out_if (out_if)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: every two accepted inputs form a pair that yields sum then diff.
    logic [31:0] exp_q[$];
    logic        have_a;
    logic [31:0] a_hold;
    int          ocnt;

    logic        g_vld, g_rdy, g_last, g_ofire, g_ifire;
    logic [31:0] g_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_half(input logic [15:0] a, input logic [15:0] b, input bit sub);
        int ai, bi, r;
        ai = int'($signed(a));
        bi = int'($signed(b));
        r  = sub ? (ai - bi) : (ai + bi);
`ifdef BFLY_ROUND_EN
        r = r + 1;
`endif
        r = r >>> 1;
        return r[15:0];
    endfunction

    function automatic logic [31:0] ref_bfly(input logic [31:0] a, input logic [31:0] b, input bit sub);
        return {ref_half(a[31:16], b[31:16], sub), ref_half(a[15:0], b[15:0], sub)};
    endfunction

    // Called at posedge+1 with inputs set; samples at the negedge, returns at next posedge+1.
    task automatic cyc();
        logic [31:0] e;
        @(negedge clk);
        g_vld   = out_if.strm_vld;
        g_dat   = out_if.strm_dat;
        g_last  = out_if.strm_last;
        g_rdy   = in_if.strm_rdy;
        g_ofire = out_if.strm_vld && out_if.strm_rdy;
        g_ifire = in_if.strm_vld && in_if.strm_rdy;
        if (g_ofire) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", {31'd0, g_ofire}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_dat", g_dat, e);
                chk("out_last", {31'd0, g_last}, {31'd0, ((ocnt % N) == N - 1)});
                ocnt++;
            end
        end
        if (g_ifire) begin
            if (have_a) begin
                exp_q.push_back(ref_bfly(a_hold, in_if.strm_dat, 1'b0));
                exp_q.push_back(ref_bfly(a_hold, in_if.strm_dat, 1'b1));
                have_a = 1'b0;
            end else begin
                a_hold = in_if.strm_dat;
                have_a = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_vld"},  {31'd0, out_if.strm_vld},  32'd0);
        chk({tag, "_dat"},  out_if.strm_dat,           32'd0);
        chk({tag, "_last"}, {31'd0, out_if.strm_last}, 32'd0);
        chk({tag, "_rdy"},  {31'd0, in_if.strm_rdy},   32'd1);
        exp_q.delete();
        have_a = 1'b0;
        ocnt   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk({tag, "_rdy_after"}, {31'd0, in_if.strm_rdy}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int n);
        in_if.strm_vld = 1'b0;
        out_if.strm_rdy = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] a_v, b_v, s_exp;
        logic        l_exp;
        int          first_out, nout, nlast;

        in_if.strm_vld  = 1'b0;
        in_if.strm_dat  = '0;
        in_if.strm_last = 1'b0;
        out_if.strm_rdy = 1'b1;
        have_a = 1'b0;
        a_hold = '0;
        ocnt   = 0;
        #2;
        apply_reset("rst0");

        // Basic pair {3,-3} then {0,0}
        in_if.strm_vld = 1'b1;
        in_if.strm_dat = {16'd3, 16'hFFFD};
        cyc();
        in_if.strm_dat = 32'd0;
        cyc();
        in_if.strm_vld = 1'b0;
        cyc();
`ifdef BFLY_ROUND_EN
        s_exp = {16'd2, 16'hFFFF};
`else
        s_exp = {16'd1, 16'hFFFE};
`endif
        chk("basic_sum_vld", {31'd0, g_vld}, 32'd1);
        chk("basic_sum", g_dat, s_exp);
        cyc();
        chk("basic_diff", g_dat, s_exp);
        drain("basic", 3);

        // Extremes: identical max/min operands
        in_if.strm_vld = 1'b1;
        in_if.strm_dat = {16'h7FFF, 16'h8000};
        cyc();
        cyc();
        in_if.strm_vld = 1'b0;
        cyc();
        chk("ext_sum", g_dat, {16'h7FFF, 16'h8000});
        cyc();
        chk("ext_diff", g_dat, 32'd0);
        drain("ext", 3);

        // Full rate, frame counting from a fresh reset
        apply_reset("rst1");
        first_out = -1;
        nout = 0;
        nlast = 0;
        for (int i = 0; i < 20; i++) begin
            in_if.strm_vld = (i < 16);
            in_if.strm_dat = $urandom;
            cyc();
            if (i < 16) chk("fr_rdy", {31'd0, g_rdy}, 32'd1);
            if (g_ofire) begin
                if (first_out < 0) first_out = i;
                nout++;
                if (g_last) nlast++;
            end
            if (i >= 2 && i <= 17) chk("fr_consec", {31'd0, g_ofire}, 32'd1);
        end
        chk("fr_first", first_out, 32'd2);
        chk("fr_count", nout, 32'd16);
        chk("fr_nlast", nlast, 32'd2);
        drain("fr", 2);

        // Back-pressure on the sum
        a_v = $urandom;
        b_v = $urandom;
        in_if.strm_vld = 1'b1;
        in_if.strm_dat = a_v;
        cyc();
        in_if.strm_dat = b_v;
        cyc();
        out_if.strm_rdy = 1'b0;
        in_if.strm_dat = $urandom;
        s_exp = ref_bfly(a_v, b_v, 1'b0);
        l_exp = ((ocnt % N) == N - 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_vld",  {31'd0, g_vld},  32'd1);
            chk("bp_dat",  g_dat, s_exp);
            chk("bp_last", {31'd0, g_last}, {31'd0, l_exp});
            chk("bp_rdy",  {31'd0, g_rdy},  32'd0);
        end
        out_if.strm_rdy = 1'b1;
        cyc();
        chk("bp_release_in", {31'd0, g_ifire}, 32'd1);
        in_if.strm_dat = $urandom;
        cyc();
        drain("bp", 4);

        // Sparse input: valid toggles every cycle
        for (int i = 0; i < 12; i++) begin
            in_if.strm_vld = ((i % 2) == 0);
            in_if.strm_dat = $urandom;
            cyc();
            if (i == 5 || i == 9) chk("sp_gap", {31'd0, g_vld}, 32'd0);
            if (i == 3 || i == 7) chk("sp_sum_vld", {31'd0, g_vld}, 32'd1);
        end
        drain("sp", 4);

        // Reset with a diff pending and an A operand held
        in_if.strm_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_if.strm_dat = $urandom;
            cyc();
        end
        out_if.strm_rdy = 1'b0;
        in_if.strm_vld = 1'b0;
        cyc();
        chk("mid_pending_vld", {31'd0, g_vld}, 32'd1);
        apply_reset("rst2");
        out_if.strm_rdy = 1'b1;
        in_if.strm_vld = 1'b1;
        a_v = $urandom;
        b_v = $urandom;
        in_if.strm_dat = a_v;
        cyc();
        in_if.strm_dat = b_v;
        cyc();
        in_if.strm_vld = 1'b0;
        cyc();
        chk("mid_sum", g_dat, ref_bfly(a_v, b_v, 1'b0));
        cyc();
        chk("mid_diff", g_dat, ref_bfly(a_v, b_v, 1'b1));
        nlast = 0;
        in_if.strm_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_if.strm_vld = (i < 6);
            in_if.strm_dat = $urandom;
            cyc();
            if (g_ofire && g_last) nlast++;
        end
        chk("mid_nlast", nlast, 32'd1);
        chk("mid_ocnt", ocnt, 32'd8);
        drain("mid", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
